data_mem_arbiter: RTL and testbench

//  Shares the single-port data RAM between the ARM core's load/store port (CPU)
//  and the histogram-equalization accelerator (ACC).

---
 rtl/data_mem_arbiter_if.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data RAM arbiter, its two requesters (CPU, ACC) and the RAM.
// The slave modport is the arbiter's view; master is the requesters' and RAM's view.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              acc_req;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_gnt;
  logic              acc_rvalid;
  logic [DATA_W-1:0] acc_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  acc_req, acc_we, acc_addr, acc_wdata,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output acc_req, acc_we, acc_addr, acc_wdata,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU load/store
// port and the histogram accelerator, with a burst cap and tagged read return.
module data_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  localparam int               CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_ACC = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_ACC = 1'b1
  } owner_t;

  state_t            state_r;
  state_t            state_nxt_s;
  owner_t            last_r;
  owner_t            last_nxt_s;
  logic [CNT_W-1:0]  burst_cnt_r;
  logic [CNT_W-1:0]  burst_nxt_s;
  logic              gnt_cpu_s;
  logic              gnt_acc_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              cpu_rvalid_r;
  logic              acc_rvalid_r;

  // Saturates so a lone owner stays at the cap and yields as soon as the other asks.
  function automatic logic [CNT_W-1:0] burst_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == BURST_LAST) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Grant decision and next arbitration state.
  always_comb begin
    gnt_cpu_s   = 1'b0;
    gnt_acc_s   = 1'b0;
    state_nxt_s = ST_IDLE;
    last_nxt_s  = last_r;
    burst_nxt_s = {CNT_W{1'b0}};
    if (rst) begin
      gnt_cpu_s = 1'b0;
      gnt_acc_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cpu_req && bus.acc_req) begin
            if (last_r == OWNER_ACC) gnt_cpu_s = 1'b1;
            else                     gnt_acc_s = 1'b1;
          end else if (bus.cpu_req) begin
            gnt_cpu_s = 1'b1;
          end else if (bus.acc_req) begin
            gnt_acc_s = 1'b1;
          end else begin
            gnt_cpu_s = 1'b0;
          end
        end
        ST_OWN_CPU: begin
          if (bus.cpu_req) begin
            if (bus.acc_req && (burst_cnt_r == BURST_LAST)) gnt_acc_s = 1'b1;
            else                                            gnt_cpu_s = 1'b1;
          end else if (bus.acc_req) begin
            gnt_acc_s = 1'b1;
          end else begin
            gnt_acc_s = 1'b0;
          end
        end
        ST_OWN_ACC: begin
          if (bus.acc_req) begin
            if (bus.cpu_req && (burst_cnt_r == BURST_LAST)) gnt_cpu_s = 1'b1;
            else                                            gnt_acc_s = 1'b1;
          end else if (bus.cpu_req) begin
            gnt_cpu_s = 1'b1;
          end else begin
            gnt_cpu_s = 1'b0;
          end
        end
        default: begin
          gnt_cpu_s = 1'b0;
          gnt_acc_s = 1'b0;
        end
      endcase
    end

    if (gnt_cpu_s) begin
      state_nxt_s = ST_OWN_CPU;
      last_nxt_s  = OWNER_CPU;
      burst_nxt_s = (state_r == ST_OWN_CPU) ? burst_inc(burst_cnt_r) : {CNT_W{1'b0}};
    end else if (gnt_acc_s) begin
      state_nxt_s = ST_OWN_ACC;
      last_nxt_s  = OWNER_ACC;
      burst_nxt_s = (state_r == ST_OWN_ACC) ? burst_inc(burst_cnt_r) : {CNT_W{1'b0}};
    end else begin
      state_nxt_s = ST_IDLE;
      burst_nxt_s = {CNT_W{1'b0}};
    end
  end

  // RAM request mux from the granted requester; quiet bus when nobody is granted.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (gnt_cpu_s) begin
      mem_we_s    = bus.cpu_we;
      mem_addr_s  = bus.cpu_addr;
      mem_wdata_s = bus.cpu_wdata;
    end else if (gnt_acc_s) begin
      mem_we_s    = bus.acc_we;
      mem_addr_s  = bus.acc_addr;
      mem_wdata_s = bus.acc_wdata;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      last_r      <= OWNER_ACC;
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      last_r      <= last_nxt_s;
      burst_cnt_r <= burst_nxt_s;
    end
  end

  // Read tag: routes next cycle's RAM data to the requester that issued the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid_r <= 1'b0;
      acc_rvalid_r <= 1'b0;
    end else begin
      cpu_rvalid_r <= gnt_cpu_s & ~bus.cpu_we;
      acc_rvalid_r <= gnt_acc_s & ~bus.acc_we;
    end
  end

  assign bus.cpu_gnt    = gnt_cpu_s;
  assign bus.acc_gnt    = gnt_acc_s;
  assign bus.mem_en     = gnt_cpu_s | gnt_acc_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.cpu_rvalid = cpu_rvalid_r;
  assign bus.acc_rvalid = acc_rvalid_r;
  assign bus.cpu_rdata  = cpu_rvalid_r ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.acc_rdata  = acc_rvalid_r ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a randomized run
// against a requester-level reference model of round-robin-with-burst-cap arbitration.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ram    [0:255];
  logic [31:0] shadow [0:255];

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // RAM with one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  a_cpu_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.cpu_req && !bus.cpu_gnt) |=> (!bus.cpu_req || $stable({bus.cpu_we, bus.cpu_addr, bus.cpu_wdata})));
  a_acc_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.acc_req && !bus.acc_gnt) |=> (!bus.acc_req || $stable({bus.acc_we, bus.acc_addr, bus.acc_wdata})));

  task automatic set_cpu(input logic r, input logic w, input logic [15:0] ad, input logic [31:0] d);
    bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = ad; bus.cpu_wdata = d;
  endtask

  task automatic set_acc(input logic r, input logic w, input logic [15:0] ad, input logic [31:0] d);
    bus.acc_req = r; bus.acc_we = w; bus.acc_addr = ad; bus.acc_wdata = d;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0]   ctl;
    logic [111:0] dat;
    set_cpu(1'b1, 1'b0, 16'h0010, 32'h0);
    set_acc(1'b1, 1'b1, 16'h0011, 32'hA5A5A5A5);
    @(negedge clk); #1;
    ctl = {bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.acc_rvalid};
    dat = {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.acc_rdata};
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=000000", ctl); end
    checks++; if (dat !== 112'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", dat); end
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_cpu(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    #1;
    checks++; if ({bus.cpu_gnt, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL preload_write got=%b exp=11", {bus.cpu_gnt, bus.mem_we}); end
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 16'h0010, 32'h0);
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we} !== 4'b1010) begin errors++; $display("FAIL read_grant got=%b exp=1010", {bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL read_addr got=%h exp=0010", bus.mem_addr); end
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    checks++; if ({bus.cpu_rvalid, bus.acc_rvalid} !== 2'b10) begin errors++; $display("FAIL read_rvalid got=%b exp=10", {bus.cpu_rvalid, bus.acc_rvalid}); end
    checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got=%h exp=deadbeef", bus.cpu_rdata); end
    checks++; if (bus.acc_rdata !== 32'h0) begin errors++; $display("FAIL read_other_rdata got=%h exp=0", bus.acc_rdata); end
  endtask

  task automatic test_round_robin();
    logic exp_cpu;
    do_reset();
    set_cpu(1'b1, 1'b1, 16'h0040, 32'h11110000);
    set_acc(1'b1, 1'b1, 16'h0041, 32'h22220000);
    for (int i = 0; i < 10; i++) begin
      exp_cpu = ((i / MAX_BURST) % 2) == 0;
      #1;
      checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.mem_en} !== {exp_cpu, !exp_cpu, 1'b1}) begin
        errors++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.acc_gnt, bus.mem_en}, {exp_cpu, !exp_cpu, 1'b1});
      end
      checks++; if (bus.mem_addr !== (exp_cpu ? 16'h0040 : 16'h0041)) begin
        errors++; $display("FAIL rr_addr cyc=%0d got=%h exp=%h", i, bus.mem_addr, exp_cpu ? 16'h0040 : 16'h0041);
      end
      @(negedge clk);
    end
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_owner_drop();
    do_reset();
    set_acc(1'b1, 1'b1, 16'h0050, 32'h0A0A0A0A);
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt} !== 2'b01) begin errors++; $display("FAIL drop_first got=%b exp=01", {bus.cpu_gnt, bus.acc_gnt}); end
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 16'h0051, 32'h0C0C0C0C);
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt} !== 2'b01) begin errors++; $display("FAIL drop_second got=%b exp=01", {bus.cpu_gnt, bus.acc_gnt}); end
    @(negedge clk);
    set_acc(1'b0, 1'b1, 16'h0050, 32'h0A0A0A0A);
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.mem_en} !== 3'b101) begin errors++; $display("FAIL drop_switch got=%b exp=101", {bus.cpu_gnt, bus.acc_gnt, bus.mem_en}); end
    @(negedge clk);
    set_acc(1'b1, 1'b1, 16'h0050, 32'h0A0A0A0A);
    for (int k = 0; k < MAX_BURST - 1; k++) begin
      #1;
      checks++; if ({bus.cpu_gnt, bus.acc_gnt} !== 2'b10) begin errors++; $display("FAIL drop_burst k=%0d got=%b exp=10", k, {bus.cpu_gnt, bus.acc_gnt}); end
      @(negedge clk);
    end
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt} !== 2'b01) begin errors++; $display("FAIL drop_cap got=%b exp=01", {bus.cpu_gnt, bus.acc_gnt}); end
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 16'h0005, 32'h12345678);
    #1;
    checks++; if ({bus.cpu_gnt, bus.mem_en, bus.mem_we} !== 3'b111) begin errors++; $display("FAIL wr_ctl got=%b exp=111", {bus.cpu_gnt, bus.mem_en, bus.mem_we}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {16'h0005, 32'h12345678}) begin errors++; $display("FAIL wr_bus got=%h exp=000512345678", {bus.mem_addr, bus.mem_wdata}); end
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b1, 1'b0, 16'h0005, 32'h0);
    #1;
    checks++; if ({bus.acc_gnt, bus.mem_we, bus.cpu_rvalid} !== 3'b100) begin errors++; $display("FAIL rd_ctl got=%b exp=100", {bus.acc_gnt, bus.mem_we, bus.cpu_rvalid}); end
    @(negedge clk);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
    #1;
    checks++; if ({bus.acc_rvalid, bus.cpu_rvalid, bus.mem_we} !== 3'b100) begin errors++; $display("FAIL rd_rvalid got=%b exp=100", {bus.acc_rvalid, bus.cpu_rvalid, bus.mem_we}); end
    checks++; if (bus.acc_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata got=%h exp=12345678", bus.acc_rdata); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 16'h0010, 32'h0);
    #1;
    checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstrd_gnt got=%b exp=1", bus.cpu_gnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    set_acc(1'b1, 1'b0, 16'h0011, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.acc_rvalid} !== 6'b0) begin
        errors++; $display("FAIL rstrd_ctl k=%0d got=%b exp=000000", k, {bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.acc_rvalid});
      end
      checks++; if ({bus.mem_addr, bus.cpu_rdata} !== 48'h0) begin errors++; $display("FAIL rstrd_data k=%0d got=%h exp=0", k, {bus.mem_addr, bus.cpu_rdata}); end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.cpu_rvalid} !== 3'b100) begin errors++; $display("FAIL rstrd_restart got=%b exp=100", {bus.cpu_gnt, bus.acc_gnt, bus.cpu_rvalid}); end
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we} !== 4'b0) begin
        errors++; $display("FAIL idle_ctl k=%0d got=%b exp=0000", k, {bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we});
      end
    end
    @(negedge clk);
    set_cpu(1'b1, 1'b1, 16'h0060, 32'h1);
    set_acc(1'b1, 1'b1, 16'h0061, 32'h2);
    #1;
    checks++; if ({bus.cpu_gnt, bus.acc_gnt} !== 2'b01) begin errors++; $display("FAIL idle_resume got=%b exp=01", {bus.cpu_gnt, bus.acc_gnt}); end
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_random();
    int          g, m_owner, m_run, m_last, rv_who, oth;
    logic [31:0] rv_data;
    logic        c, a, own_req, oth_req, cpu_hold, acc_hold, e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    do_reset();
    m_owner = 0; m_run = 0; m_last = 2; rv_who = 0; rv_data = 32'h0;
    cpu_hold = 1'b0; acc_hold = 1'b0;
    for (int i = 0; i < 316; i++) begin
      if (i < 16) begin
        set_cpu(1'b1, 1'b1, 16'h0020 + 16'(i), $urandom);
        set_acc(1'b0, 1'b0, 16'h0, 32'h0);
      end else begin
        if (!cpu_hold) set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'h0020 + 16'($urandom_range(0, 15)), $urandom);
        if (!acc_hold) set_acc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'h0020 + 16'($urandom_range(0, 15)), $urandom);
      end
      c = bus.cpu_req;
      a = bus.acc_req;
      // owner codes: 0 none, 1 CPU, 2 ACC; m_run counts consecutive accesses of the owner
      if (m_owner == 0) begin
        g = (c && a) ? ((m_last == 1) ? 2 : 1) : (c ? 1 : (a ? 2 : 0));
      end else begin
        oth     = 3 - m_owner;
        own_req = (m_owner == 1) ? c : a;
        oth_req = (m_owner == 1) ? a : c;
        if (own_req) g = (oth_req && m_run >= MAX_BURST) ? oth : m_owner;
        else         g = oth_req ? oth : 0;
      end
      e_we    = (g == 1) ? bus.cpu_we    : ((g == 2) ? bus.acc_we    : 1'b0);
      e_addr  = (g == 1) ? bus.cpu_addr  : ((g == 2) ? bus.acc_addr  : 16'h0);
      e_wdata = (g == 1) ? bus.cpu_wdata : ((g == 2) ? bus.acc_wdata : 32'h0);
      #1;
      checks++; if ({bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we} !== {g == 1, g == 2, g != 0, e_we}) begin
        errors++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.acc_gnt, bus.mem_en, bus.mem_we}, {g == 1, g == 2, g != 0, e_we});
      end
      checks++; if ({bus.mem_addr, bus.mem_wdata} !== {e_addr, e_wdata}) begin
        errors++; $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", i, {bus.mem_addr, bus.mem_wdata}, {e_addr, e_wdata});
      end
      checks++; if ({bus.cpu_rvalid, bus.acc_rvalid, bus.cpu_rdata, bus.acc_rdata} !==
                    {rv_who == 1, rv_who == 2, (rv_who == 1) ? rv_data : 32'h0, (rv_who == 2) ? rv_data : 32'h0}) begin
        errors++; $display("FAIL rnd_ret cyc=%0d got=%b/%b %h/%h exp_who=%0d exp_data=%h", i,
                           bus.cpu_rvalid, bus.acc_rvalid, bus.cpu_rdata, bus.acc_rdata, rv_who, rv_data);
      end
      if (g == 0) begin
        m_owner = 0; m_run = 0;
      end else begin
        m_run   = (g == m_owner) ? m_run + 1 : 1;
        m_owner = g;
        m_last  = g;
      end
      rv_who = (g != 0 && !e_we) ? g : 0;
      if (g != 0 && !e_we) rv_data = shadow[e_addr[7:0]];
      if (g != 0 && e_we)  shadow[e_addr[7:0]] = e_wdata;
      cpu_hold = c && (g != 1);
      acc_hold = a && (g != 2);
      @(negedge clk);
    end
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    set_cpu(1'b0, 1'b0, 16'h0, 32'h0);
    set_acc(1'b0, 1'b0, 16'h0, 32'h0);
    test_reset();
    test_single_read();
    test_round_robin();
    test_owner_drop();
    test_write_then_read();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
